hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage RISC-V core, driving stall, flush and enable signals for the PC and the pipeline registers.
- Detects load-use hazards (ID vs EX) and inserts a one-cycle bubble.
- Flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Freezes the whole pipeline while data memory withholds ready, with a timeout watchdog.
- Keeps saturating stall and flush performance counters.
- Complements the forwarding logic, which cannot cover load-use or memory wait.

Parameters:
MEM_TIMEOUT, 16, max consecutive wait cycles before the error state (≥2)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  core clock, rising edge
arst_n  in  1  asynchronous active-low reset
rs1_ID  in  5  source reg 1 of the instruction in ID
rs2_ID  in  5  source reg 2 of the instruction in ID
rd_EX  in  5  destination reg of the instruction in EX
mem_read_EX  in  1  instruction in EX is a load
branch_taken_EX  in  1  branch/jump in EX resolved taken
dmem_req_MEM  in  1  MEM stage has an active memory access
dmem_ready  in  1  data memory completes the access this cycle
pc_write  out  1  PC register enable
if_id_write  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID loads a NOP
id_ex_flush  out  1  ID/EX loads a bubble (control bits zero)
ex_mem_write  out  1  EX/MEM register enable
mem_wb_write  out  1  MEM/WB register enable
mem_error  out  1  sticky memory-timeout flag
stall_cnt  out  CNT_W  cycles with pc_write=0
flush_cnt  out  CNT_W  cycles with if_id_flush=1

Behaviour:
- Clocking and reset: single clock domain. arst_n low asynchronously forces:
  - state=RUN, wait counter=0, mem_error=0, stall_cnt=0, flush_cnt=0.
  - Freeze outputs are not asserted during reset: all *_write=1, all flushes=0.
- State vs decode: state, wait counter, error flag and perf counters are registered. Control outputs are combinational from state and inputs, so they take effect in the same cycle.
- States: RUN, MEM_WAIT, ERROR (2-bit encoding).
- Freeze condition F:
  - (state==RUN && dmem_req_MEM && !dmem_ready) || (state==MEM_WAIT && !dmem_ready) || state==ERROR.
  - When F: pc_write, if_id_write, ex_mem_write and mem_wb_write = 0; both flushes = 0.
  - Freeze overrides everything.
- Load-use hazard LU: mem_read_EX && rd_EX!=0 && (rd_EX==rs1_ID || rd_EX==rs2_ID).
- Branch BR: branch_taken_EX.
- Decision when not F, with BR taking priority over LU (the instruction in ID is squashed anyway):
  - BR: pc_write=1, if_id_write=1, if_id_flush=1, id_ex_flush=1.
  - else LU: pc_write=0, if_id_write=0, id_ex_flush=1, if_id_flush=0.
  - else: all writes=1, no flushes.
  - ex_mem_write and mem_wb_write are 1 in all three cases.
- Transitions:
  - RUN → MEM_WAIT when dmem_req_MEM && !dmem_ready; wait counter ← 1.
  - MEM_WAIT, dmem_ready=1: the freeze lifts that same cycle, the normal BR/LU decision applies, and the next state is RUN (wait counter ← 0).
  - MEM_WAIT, dmem_ready=0, wait counter==MEM_TIMEOUT-1: go to ERROR and set mem_error.
  - MEM_WAIT, dmem_ready=0, otherwise: wait counter increments.
  - ERROR: absorbing until reset; mem_error stays 1.
- Branch during freeze: BR is held stable by the frozen pipeline and is applied in the release cycle. There is no separate pending register.
- Counters:
  - stall_cnt increments on every cycle with pc_write=0, covering both LU and F.
  - flush_cnt increments on every cycle with if_id_flush=1.
  - Both saturate at all-ones and do not wrap.
- Back-to-back memory accesses: a release cycle with dmem_req_MEM from the next instruction is not evaluated until the next cycle (the state is RUN then).

Decomposition:
- Shared package hazard_pkg holds:
  - state encoding constants ST_RUN=2'd0, ST_MEM_WAIT=2'd1, ST_ERROR=2'd2.
  - REG_ZERO=5'd0.
- One sub-module, sat_counter (parameter W; inputs clk, arst_n, inc; output count), instantiated twice for the perf counters.
- The hazard decode stays inline.

Test Plan:
- Load-use: mem_read_EX=1, rd_EX=5, rs2_ID=5, no memory request → pc_write=0, if_id_write=0, id_ex_flush=1 for one cycle; stall_cnt 0→1.
- x0 load: mem_read_EX=1, rd_EX=0, rs1_ID=0 → no stall, all writes=1, stall_cnt unchanged.
- Branch with load-use: branch_taken_EX=1 and the LU condition both true → if_id_flush=1, id_ex_flush=1, pc_write=1; flush_cnt +1; stall_cnt unchanged.
- Memory wait: dmem_req_MEM=1, dmem_ready=0 for 3 cycles then 1 → all writes=0 for exactly 3 cycles; the 4th cycle runs normally; state returns to RUN; stall_cnt +3.
- Timeout: dmem_req_MEM=1, dmem_ready held 0 with MEM_TIMEOUT=4 → mem_error=1 after 4 frozen cycles. Freeze persists after dmem_ready=1; arst_n pulse clears all state and counters.
- Saturation: force stall_cnt to all-ones (CNT_W=4 build) and cause a further LU stall → stall_cnt stays 4'hF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the architectural zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters;
// it holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use bubbles, taken-branch
// flushes, and a data-memory wait freeze guarded by a timeout watchdog.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic [4:0]       rd_EX,
    input  logic             mem_read_EX,
    input  logic             branch_taken_EX,
    input  logic             dmem_req_MEM,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              freeze;
    logic              load_use;

    assign freeze = ((state == ST_RUN) && dmem_req_MEM && !dmem_ready)
                 || ((state == ST_MEM_WAIT) && !dmem_ready)
                 || (state == ST_ERROR);

    assign load_use = mem_read_EX && (rd_EX != REG_ZERO)
                   && ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));

    // Freeze wins over branch, branch wins over load-use; reset leaves the
    // pipeline enabled so nothing looks stalled while arst_n is low.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if (!arst_n) begin
            pc_write = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
        end else if (branch_taken_EX) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= ST_RUN;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (dmem_req_MEM && !dmem_ready) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state     <= ST_ERROR;
                        mem_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ERROR: begin
                    mem_error <= 1'b1;
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (!pc_write),
        .count  (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .inc    (if_id_flush),
        .count  (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4): the driver queues
// hand-computed expectations per vector, a monitor checks them mid-cycle.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic [4:0] rs1_ID = '0, rs2_ID = '0, rd_EX = '0;
    logic       mem_read_EX = 1'b0, branch_taken_EX = 1'b0;
    logic       dmem_req_MEM = 1'b0, dmem_ready = 1'b0;
    logic       pc_write, if_id_write, if_id_flush, id_ex_flush;
    logic       ex_mem_write, mem_wb_write, mem_error;
    logic [3:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk             (clk),
        .arst_n          (arst_n),
        .rs1_ID          (rs1_ID),
        .rs2_ID          (rs2_ID),
        .rd_EX           (rd_EX),
        .mem_read_EX     (mem_read_EX),
        .branch_taken_EX (branch_taken_EX),
        .dmem_req_MEM    (dmem_req_MEM),
        .dmem_ready      (dmem_ready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_write    (ex_mem_write),
        .mem_wb_write    (mem_wb_write),
        .mem_error       (mem_error),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    always #5 clk = ~clk;

    // ctrl order: {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write}
    localparam logic [5:0] NORM = 6'b110011;
    localparam logic [5:0] LUS  = 6'b000111;
    localparam logic [5:0] BRF  = 6'b111111;
    localparam logic [5:0] FRZ  = 6'b000000;

    typedef struct {
        int         id;
        logic [5:0] ctrl;
        logic       err;
        logic [3:0] st;
        logic [3:0] fl;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   vid   = 0;

    task automatic vec(input logic rst, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic mr, input logic br,
                       input logic req, input logic rdy, input logic [5:0] ctrl,
                       input logic err, input logic [3:0] st, input logic [3:0] fl);
        exp_t e;
        @(posedge clk);
        #1;
        arst_n          = !rst;
        rs1_ID          = r1;
        rs2_ID          = r2;
        rd_EX           = rd;
        mem_read_EX     = mr;
        branch_taken_EX = br;
        dmem_req_MEM    = req;
        dmem_ready      = rdy;
        e.id = vid; e.ctrl = ctrl; e.err = err; e.st = st; e.fl = fl;
        q.push_back(e);
        vid++;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [5:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write};
                n_vec++;
                if (got !== e.ctrl || mem_error !== e.err || stall_cnt !== e.st || flush_cnt !== e.fl) begin
                    n_bad++;
                    $display("FAIL vec%0d: got ctrl=%b err=%b stall=%0d flush=%0d, expected ctrl=%b err=%b stall=%0d flush=%0d",
                             e.id, got, mem_error, stall_cnt, flush_cnt, e.ctrl, e.err, e.st, e.fl);
                end
            end
        end
    end

    initial begin : driver
        int guard;
        //  rst r1 r2 rd mr br rq rdy  ctrl err st fl
        vec(1, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);   // in reset
        vec(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);
        vec(0, 1, 5, 5, 1, 0, 0, 0, LUS,  0, 0, 0);   // load-use on rs2
        vec(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 1, 0);
        vec(0, 0, 3, 0, 1, 0, 0, 0, NORM, 0, 1, 0);   // load to x0
        vec(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 1, 0);
        vec(0, 7, 0, 7, 1, 1, 0, 0, BRF,  0, 1, 0);   // branch over load-use
        vec(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 1, 1);
        vec(0, 9, 2, 9, 1, 0, 0, 0, LUS,  0, 1, 1);   // load-use on rs1
        vec(0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 2, 1);   // 3-cycle memory wait
        vec(0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 3, 1);
        vec(0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 4, 1);
        vec(0, 0, 0, 0, 0, 0, 1, 1, NORM, 0, 5, 1);   // release
        vec(0, 0, 0, 0, 0, 0, 1, 1, NORM, 0, 5, 1);   // RUN: ready request no freeze
        vec(0, 0, 0, 0, 0, 1, 1, 0, FRZ,  0, 5, 1);   // branch held under freeze
        vec(0, 0, 0, 0, 0, 1, 1, 1, BRF,  0, 6, 1);   // branch applied at release
        vec(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 6, 2);
        vec(0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 6, 2);   // back-to-back accesses
        vec(0, 0, 0, 0, 0, 0, 1, 1, NORM, 0, 7, 2);
        vec(0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 7, 2);
        vec(0, 0, 0, 0, 0, 0, 1, 1, NORM, 0, 8, 2);
        vec(0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 8, 2);   // timeout after 4 frozen cycles
        vec(0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 9, 2);
        vec(0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 10, 2);
        vec(0, 0, 0, 0, 0, 0, 1, 0, FRZ,  0, 11, 2);
        vec(0, 0, 0, 0, 0, 0, 1, 1, FRZ,  1, 12, 2);  // error state ignores ready
        vec(0, 0, 0, 0, 0, 1, 0, 0, FRZ,  1, 13, 2);
        vec(1, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);   // reset clears everything
        vec(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            vec(0, 1, 5, 5, 1, 0, 0, 0, LUS, 0, (i > 15) ? 4'd15 : 4'(i), 0);
        end
        vec(0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 15, 0);  // saturated, no wrap

        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
